// File: rtl/cmp_pkg.sv
// Shared types for the sequential magnitude comparator: FSM state encoding
// and the one-hot {gt, eq, lt} result word.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } cmp_res_t;

  localparam cmp_res_t RES_NONE = '0;

  function automatic cmp_res_t res_from_chunk(input cmp_res_t chunk_res);
    cmp_res_t r;
    r    = RES_NONE;
    r.gt = chunk_res.gt;
    r.lt = chunk_res.lt;
    return r;
  endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Combinational unsigned comparator for one CHUNK-bit slice of the operands.
module cmp_chunk
  import cmp_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output cmp_res_t         res
);

  always_comb begin
    res    = RES_NONE;
    res.gt = (a > b);
    res.eq = (a == b);
    res.lt = (a < b);
  end

endmodule

// File: rtl/seq_mag_comparator.sv
// Multi-cycle magnitude comparator: walks the operands one chunk per cycle,
// MSB chunk first, and stops at the first chunk that differs.
module seq_mag_comparator
  import cmp_pkg::*;
#(
  parameter  int WIDTH      = 32,
  parameter  int CHUNK      = 8,
  localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK,
  localparam int NCHUNK     = WIDTH / CHUNK_SAFE,
  localparam int CNT_W      = $clog2(NCHUNK) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a_greater,
  output logic             a_equal,
  output logic             a_less,
  output logic [CNT_W-1:0] out_cycles
);

  localparam int IDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int NSLOT = 1 << IDX_W;
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  if (CHUNK < 1) begin : g_bad_chunk
    $error("seq_mag_comparator: CHUNK must be at least 1");
  end
  if ((WIDTH % CHUNK_SAFE) != 0) begin : g_bad_ratio
    $error("seq_mag_comparator: WIDTH must be a multiple of CHUNK");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sgn_q, sgn_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  cmp_res_t         res_q, res_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;

  logic [WIDTH-1:0] a_view, b_view;
  logic [CHUNK-1:0] a_slot [NSLOT];
  logic [CHUNK-1:0] b_slot [NSLOT];
  logic [CHUNK-1:0] chunk_a, chunk_b;
  cmp_res_t         chunk_res;
  logic             last_chunk;

  // Flipping both sign bits maps two's complement order onto unsigned order.
  assign a_view = a_q ^ (sgn_q ? MSB_MASK : '0);
  assign b_view = b_q ^ (sgn_q ? MSB_MASK : '0);

  for (genvar s = 0; s < NSLOT; s++) begin : g_slot
    if (s < NCHUNK) begin : g_live
      assign a_slot[s] = a_view[WIDTH-1-s*CHUNK_SAFE -: CHUNK];
      assign b_slot[s] = b_view[WIDTH-1-s*CHUNK_SAFE -: CHUNK];
    end else begin : g_pad
      assign a_slot[s] = '0;
      assign b_slot[s] = '0;
    end
  end

  assign chunk_a    = a_slot[idx_q];
  assign chunk_b    = b_slot[idx_q];
  assign last_chunk = (idx_q == IDX_W'(NCHUNK - 1));

  cmp_chunk #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .a  (chunk_a),
    .b  (chunk_b),
    .res(chunk_res)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    idx_d   = idx_q;
    res_d   = res_q;
    cyc_d   = cyc_q;

    if (flush) begin
      state_d = IDLE;
      idx_d   = '0;
      res_d   = RES_NONE;
      cyc_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_d     = a;
            b_d     = b;
            sgn_d   = signed_mode;
            idx_d   = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          if (!chunk_res.eq) begin
            res_d   = res_from_chunk(chunk_res);
            cyc_d   = CNT_W'(idx_q) + CNT_W'(1);
            state_d = DONE;
          end else if (last_chunk) begin
            res_d    = RES_NONE;
            res_d.eq = 1'b1;
            cyc_d    = CNT_W'(NCHUNK);
            state_d  = DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
            idx_d   = '0;
            res_d   = RES_NONE;
            cyc_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          res_d   = RES_NONE;
          cyc_d   = '0;
        end
      endcase
    end
  end

  // Operand registers carry no reset; they are only read while in RUN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      res_q   <= RES_NONE;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      cyc_q   <= cyc_d;
    end
    a_q   <= a_d;
    b_q   <= b_d;
    sgn_q <= sgn_d;
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign a_greater  = res_q.gt;
  assign a_equal    = res_q.eq;
  assign a_less     = res_q.lt;
  assign out_cycles = cyc_q;

endmodule

// File: doc/seq_mag_comparator.md
SEQ_MAG_COMPARATOR -- requirements
Module: seq_mag_comparator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 8, meaning bits compared per clock cycle.
REQ-003 The block SHALL have derived constant NCHUNK = WIDTH/CHUNK, and CNT_W = $clog2(NCHUNK)+1.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset, with these ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- flush  input  1  synchronous abort to IDLE.
- in_valid  input  1  operands are presented.
- in_ready  output  1  block accepts operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- signed_mode  input  1  when 1, operands are compared as two's complement.
- out_valid  output  1  result is available.
- out_ready  input  1  consumer takes the result.
- a_greater  output  1  result A>B.
- a_equal  output  1  result A==B.
- a_less  output  1  result A<B.
- out_cycles  output  CNT_W  number of chunks examined (1..NCHUNK).

Function
REQ-005 The block SHALL use three states: IDLE, RUN and DONE.
REQ-006 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-007 On in_valid&&in_ready, the block SHALL register a, b and signed_mode, set chunk index to 0 (MSB chunk) and enter RUN.
REQ-008 In signed mode, the MSB of both captured operands SHALL be inverted, so that an unsigned compare yields the signed result.
REQ-009 In RUN, one chunk per cycle SHALL be compared, MSB chunk first; chunk k covers bits [WIDTH-1-k*CHUNK -: CHUNK].
REQ-010 When a chunk differs, the block SHALL latch gt/lt from that chunk, set out_cycles=k+1 and enter DONE (early termination).
REQ-011 When chunk NCHUNK-1 is equal, the block SHALL latch a_equal=1, set out_cycles=NCHUNK and enter DONE.
REQ-012 Latency: out_valid SHALL rise k+1 clock edges after the accepting edge, where k is the index of the deciding chunk.
REQ-013 Exactly one of a_greater/a_equal/a_less SHALL be 1 while out_valid=1.
REQ-014 Result outputs SHALL hold stable while out_valid=1 and out_ready=0, for any duration.
REQ-015 On out_valid&&out_ready, the block SHALL enter IDLE; in_ready SHALL rise on the next cycle.
REQ-016 in_valid SHALL be ignored outside IDLE; there is no result overwrite.
REQ-017 Outside DONE, a_greater, a_equal, a_less and out_cycles SHALL be 0.
REQ-018 flush=1 in any state SHALL force IDLE on the next edge and discard the operation; flush has priority over both handshakes.
REQ-019 In IDLE, simultaneous flush and in_valid SHALL result in nothing being accepted.
REQ-020 WIDTH%CHUNK != 0 or CHUNK<1 SHALL be an elaboration error; CHUNK==WIDTH SHALL be legal, with single-cycle RUN.

Reset
REQ-021 While rst_n=0 at a clock edge, the block SHALL go to state IDLE and set in_ready=1 after the edge.
REQ-022 During reset, out_valid, a_greater, a_equal, a_less, out_cycles and the chunk index SHALL all be 0.
REQ-023 Reset mid-RUN or mid-DONE SHALL abandon the operation without producing any output pulse.

Structure
REQ-024 Package cmp_pkg SHALL hold the state enum (IDLE, RUN, DONE) and a packed result typedef {gt, eq, lt}.
REQ-025 Sub-module cmp_chunk SHALL be a combinational CHUNK-bit comparator producing gt/eq/lt, instantiated once on the currently indexed chunk.
REQ-026 Operand registers SHALL be sliced by index; no shift-register copy of the operands SHALL be kept.
REQ-027 The target RTL size SHALL be 120-400 lines.

Verification (WIDTH=32, CHUNK=8)
REQ-028 Equal operands: a=b=0x12345678, unsigned -> a_equal=1, out_cycles=4, out_valid 4 edges after accept.
REQ-029 MSB chunk differs: a=0x80000000, b=0x7FFFFFFF -> unsigned: a_greater=1, out_cycles=1; signed: a_less=1, out_cycles=1.
REQ-030 Mid chunk differs: a=0x000000FF, b=0x00000100, unsigned -> a_less=1, out_cycles=3.
REQ-031 Backpressure: out_ready=0 for 10 cycles with in_valid=1 and new operands -> outputs unchanged, in_ready=0, new operands not captured.
REQ-032 Abort: flush pulse in RUN, then separately rst_n=0 in DONE -> IDLE and out_valid=0 the next cycle, with no stale result afterwards.
REQ-033 Back-to-back: out_ready held 1 and in_valid held 1 with a=5, b=3 then a=-1, b=1 signed -> gt (out_cycles=4) then lt (out_cycles=1), each accepted one cycle after the previous result handshake.
